fbuf_fill_ctrl: RTL and testbench



---
 rtl/fbuf_pkg.sv | 18 +
 rtl/fbuf_rect_walker.sv | 75 +++++++
 rtl/fbuf_fill_ctrl.sv | 147 ++++++++++++++
 tb/tb_fbuf_fill_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fbuf_pkg.sv
// Shared framebuffer geometry, controller state encoding and the
// linear pixel-address helper used by the fill controller and its walker.
package fbuf_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int ADDR_W    = 17;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

  typedef enum logic {TURN_FILL = 1'b0, TURN_PIXEL = 1'b1} turn_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/fbuf_rect_walker.sv
// Raster walker for the fill engine: clips the rectangle on load, then steps
// column/row counters and a row-base address one pixel per advance.
module fbuf_rect_walker
  import fbuf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [X_W-1:0]    x0_i,
  input  logic [Y_W-1:0]    y0_i,
  input  logic [X_W-1:0]    w_i,
  input  logic [Y_W-1:0]    h_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam logic [X_W-1:0] W_LIM = X_W'(FB_WIDTH);
  localparam logic [Y_W-1:0] H_LIM = Y_W'(FB_HEIGHT);

  logic [X_W-1:0]    w_room, w_eff;
  logic [Y_W-1:0]    h_room, h_eff;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [X_W-1:0]    col_q, col_d, wlast_q, wlast_d;
  logic [Y_W-1:0]    row_q, row_d, hlast_q, hlast_d;
  logic              col_wrap;

  // Room to the right/bottom edge; only meaningful when the origin is on screen.
  assign w_room   = W_LIM - x0_i;
  assign h_room   = H_LIM - y0_i;
  assign w_eff    = (w_i < w_room) ? w_i : w_room;
  assign h_eff    = (h_i < h_room) ? h_i : h_room;

  assign col_wrap = (col_q == wlast_q);
  assign addr_o   = base_q + ADDR_W'(col_q);
  assign last_o   = col_wrap && (row_q == hlast_q);

  always_comb begin
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    wlast_d = wlast_q;
    hlast_d = hlast_q;
    if (load_i) begin
      base_d  = pix_addr(x0_i, y0_i);
      col_d   = '0;
      row_d   = '0;
      wlast_d = w_eff - X_W'(1);
      hlast_d = h_eff - Y_W'(1);
    end else if (advance_i) begin
      if (col_wrap) begin
        col_d  = '0;
        row_d  = row_q + Y_W'(1);
        base_d = base_q + ADDR_W'(FB_WIDTH);
      end else begin
        col_d = col_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wlast_q <= '0;
      hlast_q <= '0;
    end else begin
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wlast_q <= wlast_d;
      hlast_q <= hlast_d;
    end
  end
endmodule

// File: rtl/fbuf_fill_ctrl.sv
// Framebuffer write-port owner: arbitrates single-pixel writes against the
// rectangle-fill engine and registers every BRAM write for one cycle.
//   state | meaning
//   IDLE  | waiting for fill_start; pixels always granted
//   SETUP | clip the latched rectangle, load the walker
//   RUN   | raster walk; slots alternate with the pixel source
//   DONE  | one-cycle fill_done, back to IDLE
module fbuf_fill_ctrl #(
  parameter int FBUF_ADDR_WIDTH = 17,
  parameter int FBUF_DATA_WIDTH = 12,
  parameter int FB_WIDTH        = 320,
  parameter int FB_HEIGHT       = 240
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       px_valid,
  output logic                       px_ready,
  input  logic [8:0]                 px_x,
  input  logic [7:0]                 px_y,
  input  logic [FBUF_DATA_WIDTH-1:0] px_color,
  input  logic                       fill_start,
  input  logic [8:0]                 fill_x0,
  input  logic [7:0]                 fill_y0,
  input  logic [8:0]                 fill_w,
  input  logic [7:0]                 fill_h,
  input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);
  import fbuf_pkg::*;

  localparam logic [X_W-1:0] W_LIM = X_W'(FB_WIDTH);
  localparam logic [Y_W-1:0] H_LIM = Y_W'(FB_HEIGHT);

  state_e                     state_q, state_d;
  turn_e                      turn_q, turn_d;
  logic [X_W-1:0]             x0_q, x0_d, w_q, w_d;
  logic [Y_W-1:0]             y0_q, y0_d, h_q, h_d;
  logic [FBUF_DATA_WIDTH-1:0] color_q, color_d, data_q, data_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       wr_q, wr_d;
  logic [ADDR_W-1:0]          walk_addr;
  logic                       walk_last, walk_load;
  logic                       fill_slot, px_fire, px_in_range, fill_empty;

  assign fill_empty  = (w_q == '0) || (h_q == '0) || (x0_q >= W_LIM) || (y0_q >= H_LIM);
  assign px_ready    = (state_q != RUN) || (turn_q == TURN_PIXEL);
  assign px_fire     = px_valid && px_ready;
  assign px_in_range = (px_x < W_LIM) && (px_y < H_LIM);
  // In RUN every slot not taken by a pixel handshake belongs to the fill.
  assign fill_slot   = (state_q == RUN) && !px_fire;
  assign walk_load   = (state_q == SETUP);

  fbuf_rect_walker u_walker (
    .clk_i     (aclk),
    .rst_i     (areset),
    .load_i    (walk_load),
    .x0_i      (x0_q),
    .y0_i      (y0_q),
    .w_i       (w_q),
    .h_i       (h_q),
    .advance_i (fill_slot),
    .addr_o    (walk_addr),
    .last_o    (walk_last)
  );

  always_comb begin
    state_d = state_q;
    turn_d  = TURN_FILL;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = SETUP;
          x0_d    = fill_x0;
          y0_d    = fill_y0;
          w_d     = fill_w;
          h_d     = fill_h;
          color_d = fill_color;
        end
      end
      SETUP: state_d = fill_empty ? DONE : RUN;
      RUN: begin
        turn_d = px_fire ? TURN_FILL : TURN_PIXEL;
        if (fill_slot && walk_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (fill_slot) begin
      wr_d   = 1'b1;
      addr_d = FBUF_ADDR_WIDTH'(walk_addr);
      data_d = color_q;
    end else if (px_fire && px_in_range) begin
      wr_d   = 1'b1;
      addr_d = FBUF_ADDR_WIDTH'(pix_addr(px_x, px_y));
      data_d = px_color;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      turn_q  <= TURN_FILL;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign fbuf_en_wr = wr_q;
  assign fbuf_wrea  = wr_q;
  assign fbuf_addr  = addr_q;
  assign fbuf_data  = data_q;
  assign fill_busy  = (state_q == SETUP) || (state_q == RUN);
  assign fill_done  = (state_q == DONE);
endmodule

// File: tb/tb_fbuf_fill_ctrl.sv
// Self-checking bench for fbuf_fill_ctrl: table of fills, pixel writes and
// hand-written contention / ignored-start / reset sequences against a write scoreboard.
module tb_fbuf_fill_ctrl;
  logic        aclk = 1'b0;
  logic        areset;
  logic        px_valid, px_ready;
  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic [11:0] px_color;
  logic        fill_start;
  logic [8:0]  fill_x0, fill_w;
  logic [7:0]  fill_y0, fill_h;
  logic [11:0] fill_color;
  logic        fill_busy, fill_done, fbuf_en_wr, fbuf_wrea;
  logic [16:0] fbuf_addr;
  logic [11:0] fbuf_data;

  fbuf_fill_ctrl dut (
    .aclk(aclk), .areset(areset),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w),
    .fill_h(fill_h), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  typedef struct {
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [11:0] color;
    int          n_wr;
    int          done_k;
  } fill_vec_t;

  wr_t exp_q[$];
  int  total = 0, bad = 0, wr_count = 0, done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    wr_t e;
    if (!areset) begin
      if (fill_done) done_count++;
      if (fbuf_en_wr) begin
        wr_count++;
        chk("wrea_with_en", 32'(fbuf_wrea), 32'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: actual addr=%0d data=%0h required no write", fbuf_addr, fbuf_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(fbuf_addr), 32'(e.addr));
          chk("write_data", 32'(fbuf_data), 32'(e.data));
        end
      end else begin
        chk("wrea_idle", 32'(fbuf_wrea), 32'd0);
      end
    end
  end

  task automatic push_fill(input fill_vec_t v);
    for (int yy = 0; yy < int'(v.h); yy++)
      for (int xx = 0; xx < int'(v.w); xx++)
        if (int'(v.x0) + xx < 320 && int'(v.y0) + yy < 240)
          exp_q.push_back('{addr: 17'((int'(v.y0) + yy) * 320 + int'(v.x0) + xx), data: v.color});
  endtask

  task automatic run_fill(input fill_vec_t v, input string tag, input int glitch_k);
    int k, busy_cyc, wr0, first_k;
    bit seen;
    wr0 = wr_count;
    push_fill(v);
    @(posedge aclk); #1;
    fill_start = 1'b1; fill_x0 = v.x0; fill_y0 = v.y0; fill_w = v.w; fill_h = v.h; fill_color = v.color;
    k = 0; seen = 1'b0; busy_cyc = 0; first_k = -1;
    while (!seen && k < 400) begin
      @(negedge aclk);
      if (fill_busy) busy_cyc++;
      if (fbuf_en_wr && first_k < 0) first_k = k;
      if (fill_done) begin
        seen = 1'b1;
        chk({tag, "_done_cycle"}, k, v.done_k);
        chk({tag, "_busy_at_done"}, 32'(fill_busy), 32'd0);
      end
      @(posedge aclk); #1;
      k++;
      fill_start = (k == glitch_k);
      if (k == glitch_k) begin
        fill_x0 = 9'd50; fill_y0 = 8'd50; fill_w = 9'd5; fill_h = 8'd5; fill_color = 12'hBAD;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: no fill_done within 400 cycles", tag);
    end
    repeat (2) @(posedge aclk);
    if (glitch_k >= 0) repeat (20) @(posedge aclk);
    #1;
    chk({tag, "_write_count"}, wr_count - wr0, v.n_wr);
    chk({tag, "_busy_cycles"}, busy_cyc, v.done_k - 1);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    if (v.n_wr > 0) chk({tag, "_first_write_cycle"}, first_k, 3);
  endtask

  task automatic px_write(input logic [8:0] x, input logic [7:0] y, input logic [11:0] c, input string tag);
    bit in_rng = (x < 9'd320) && (y < 8'd240);
    int wr0 = wr_count;
    if (in_rng) exp_q.push_back('{addr: 17'(int'(y) * 320 + int'(x)), data: c});
    @(posedge aclk); #1;
    px_valid = 1'b1; px_x = x; px_y = y; px_color = c;
    @(negedge aclk);
    chk({tag, "_ready"}, 32'(px_ready), 32'd1);
    @(posedge aclk); #1;
    px_valid = 1'b0;
    @(negedge aclk);
    chk({tag, "_en_next"}, 32'(fbuf_en_wr), 32'(in_rng));
    @(posedge aclk); #1;
    chk({tag, "_write_count"}, wr_count - wr0, int'(in_rng));
  endtask

  fill_vec_t tbl[9];
  fill_vec_t v;

  initial begin
    int k, hs, wr0, d0;
    bit seen;
    tbl[0] = '{9'd10,  8'd20,  9'd3, 8'd2, 12'hF00, 6,  8};
    tbl[1] = '{9'd318, 8'd239, 9'd5, 8'd4, 12'h0A5, 2,  4};
    tbl[2] = '{9'd0,   8'd0,   9'd0, 8'd5, 12'h111, 0,  2};
    tbl[3] = '{9'd5,   8'd7,   9'd1, 8'd1, 12'h222, 1,  3};
    tbl[4] = '{9'd319, 8'd0,   9'd1, 8'd3, 12'h333, 3,  5};
    tbl[5] = '{9'd320, 8'd0,   9'd2, 8'd2, 12'h444, 0,  2};
    tbl[6] = '{9'd0,   8'd240, 9'd2, 8'd2, 12'h555, 0,  2};
    tbl[7] = '{9'd100, 8'd50,  9'd4, 8'd3, 12'h666, 12, 14};
    tbl[8] = '{9'd0,   8'd0,   9'd4, 8'd0, 12'h777, 0,  2};

    areset = 1'b1; px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    #12;
    chk("rst_en_wr", 32'(fbuf_en_wr), 32'd0);
    chk("rst_addr", 32'(fbuf_addr), 32'd0);
    chk("rst_data", 32'(fbuf_data), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_px_ready", 32'(px_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_fill(tbl[i], $sformatf("vec%0d", i), -1);

    px_write(9'd5,   8'd5,   12'h0F0, "px_mid");
    px_write(9'd319, 8'd239, 12'hABC, "px_corner");
    px_write(9'd320, 8'd0,   12'hFFF, "px_x_oor");
    px_write(9'd0,   8'd240, 12'hFFF, "px_y_oor");
    px_write(9'd0,   8'd0,   12'h123, "px_origin");

    // Contention: pixel held valid from the first RUN cycle.
    exp_q.push_back('{addr: 17'd0,    data: 12'h00F});
    exp_q.push_back('{addr: 17'd1605, data: 12'h0F0});
    exp_q.push_back('{addr: 17'd1,    data: 12'h00F});
    exp_q.push_back('{addr: 17'd1605, data: 12'h0F0});
    exp_q.push_back('{addr: 17'd2,    data: 12'h00F});
    exp_q.push_back('{addr: 17'd1605, data: 12'h0F0});
    exp_q.push_back('{addr: 17'd3,    data: 12'h00F});
    wr0 = wr_count;
    @(posedge aclk); #1;
    fill_start = 1'b1; fill_x0 = 9'd0; fill_y0 = 8'd0; fill_w = 9'd4; fill_h = 8'd1; fill_color = 12'h00F;
    k = 0; hs = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge aclk);
      if (k >= 2 && !fill_done) chk($sformatf("cont_px_ready_c%0d", k), 32'(px_ready), 32'((k % 2) == 1));
      if (px_valid && px_ready && fill_busy) hs++;
      if (fill_done) begin
        seen = 1'b1;
        px_valid = 1'b0;
        chk("cont_done_cycle", k, 9);
      end
      @(posedge aclk); #1;
      k++;
      fill_start = 1'b0;
      if (k == 2) begin
        px_valid = 1'b1; px_x = 9'd5; px_y = 8'd5; px_color = 12'h0F0;
      end
    end
    px_valid = 1'b0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL cont_timeout: no fill_done within 100 cycles");
    end
    repeat (2) @(posedge aclk); #1;
    chk("cont_handshakes", hs, 3);
    chk("cont_write_count", wr_count - wr0, 7);
    chk("cont_queue_left", exp_q.size(), 0);

    v = '{9'd0, 8'd0, 9'd8, 8'd2, 12'h3C3, 16, 18};
    run_fill(v, "ignored_start", 4);

    // Reset in the middle of a 10x10 fill.
    v = '{9'd0, 8'd0, 9'd10, 8'd10, 12'h777, 100, 102};
    wr0 = wr_count;
    push_fill(v);
    @(posedge aclk); #1;
    fill_start = 1'b1; fill_x0 = v.x0; fill_y0 = v.y0; fill_w = v.w; fill_h = v.h; fill_color = v.color;
    @(posedge aclk); #1;
    fill_start = 1'b0;
    repeat (8) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    chk("rst_mid_prior_writes", wr_count - wr0, 6);
    chk("rst_mid_en_wr", 32'(fbuf_en_wr), 32'd0);
    chk("rst_mid_wrea", 32'(fbuf_wrea), 32'd0);
    chk("rst_mid_addr", 32'(fbuf_addr), 32'd0);
    chk("rst_mid_data", 32'(fbuf_data), 32'd0);
    chk("rst_mid_busy", 32'(fill_busy), 32'd0);
    chk("rst_mid_done", 32'(fill_done), 32'd0);
    exp_q.delete();
    wr0 = wr_count;
    d0 = done_count;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (30) @(posedge aclk);
    #1;
    chk("rst_after_writes", wr_count - wr0, 0);
    chk("rst_after_done", done_count - d0, 0);
    chk("rst_after_busy", 32'(fill_busy), 32'd0);

    run_fill(tbl[0], "after_rst", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
